// File: rtl/y86_alu_if.sv
// Operand/result bundle between the execute-stage operand select and the Y86 ALU.
// master: drives in_valid/a/b/control and receives ans/overflow/zf/sf/out_valid.
// slave: the ALU side, with the opposite directions.
interface y86_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       control;
  logic [WIDTH-1:0] ans;
  logic             overflow;
  logic             zf;
  logic             sf;
  logic             out_valid;

  modport master (
    output in_valid, a, b, control,
    input  ans, overflow, zf, sf, out_valid
  );

  modport slave (
    input  in_valid, a, b, control,
    output ans, overflow, zf, sf, out_valid
  );
endinterface

// File: rtl/y86_alu.sv
// Y86-64 execute-stage ALU: ADD/SUB/AND/XOR with signed overflow, ZF and SF.
// Latency 1 cycle, all outputs registered; a new operation may start every cycle.
// No back-pressure. When idle, the result and flags hold and out_valid drops.
// Ports: clk, rst (sync, active-high), bus (y86_alu_if.slave).
module y86_alu #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  y86_alu_if.slave    bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [WIDTH-1:0] ans_q, ans_d;
  logic             ovf_q, ovf_d;
  logic             zf_q,  zf_d;
  logic             sf_q,  sf_d;
  logic             vld_q, vld_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  // One shared adder: SUB is a + ~b + 1, so the carry-in is the SUB select.
  assign is_sub = (bus.control == OP_SUB);
  assign b_op   = is_sub ? ~bus.b : bus.b;
  assign sum    = bus.a + b_op + WIDTH'(is_sub);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.control)
      OP_ADD, OP_SUB: begin
        res = sum;
        // Comparing against the effective addend's sign covers both cases:
        // for SUB, sign(~b) equal to sign(a) means the original signs differ.
        res_ovf = (bus.a[WIDTH-1] == b_op[WIDTH-1]) &&
                  (sum[WIDTH-1]   != bus.a[WIDTH-1]);
      end
      OP_AND: res = bus.a & bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      default: res = '0;
    endcase
  end

  always_comb begin
    ans_d = ans_q;
    ovf_d = ovf_q;
    zf_d  = zf_q;
    sf_d  = sf_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) begin
      ans_d = res;
      ovf_d = res_ovf;
      zf_d  = (res == '0);
      sf_d  = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ans_q <= '0;
      ovf_q <= 1'b0;
      zf_q  <= 1'b0;
      sf_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      ans_q <= ans_d;
      ovf_q <= ovf_d;
      zf_q  <= zf_d;
      sf_q  <= sf_d;
      vld_q <= vld_d;
    end
  end

  assign bus.ans       = ans_q;
  assign bus.overflow  = ovf_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_y86_alu.sv
module tb_y86_alu;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_alu_if #(.WIDTH(W)) bus ();
  y86_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ans;
    logic       ovf;
    logic       zf;
    logic       sf;
  } vec_t;

  vec_t vecs[13];

  // golden state for the random phase
  logic [W-1:0] m_ans;
  logic         m_ovf, m_zf, m_sf, m_vld;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] ans, input logic ovf,
                           input logic zf, input logic sf, input logic vld);
    check({name, ".ans"}, bus.ans, ans);
    check({name, ".ovf"}, W'(bus.overflow), W'(ovf));
    check({name, ".zf"},  W'(bus.zf), W'(zf));
    check({name, ".sf"},  W'(bus.sf), W'(sf));
    check({name, ".vld"}, W'(bus.out_valid), W'(vld));
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = v;
    bus.control  = c;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: sign-extended W+1 bit arithmetic, overflow when
  // the two top bits of the wide result disagree.
  task automatic model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] wide;
    case (c)
      2'b00: begin wide = {a[W-1], a} + {b[W-1], b}; m_ans = wide[W-1:0]; m_ovf = wide[W] ^ wide[W-1]; end
      2'b01: begin wide = {a[W-1], a} - {b[W-1], b}; m_ans = wide[W-1:0]; m_ovf = wide[W] ^ wide[W-1]; end
      2'b10: begin m_ans = a & b; m_ovf = 1'b0; end
      default: begin m_ans = a ^ b; m_ovf = 1'b0; end
    endcase
    m_zf = (m_ans == '0);
    m_sf = m_ans[W-1];
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = 64'h7FFF_FFFF_FFFF_FFFF;
      1: r = 64'h8000_0000_0000_0000;
      2: r = '1;
      3: r = '0;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  initial begin
    vecs[0]  = '{"add_ovf",   2'b00, 64'h7FFF_FFFF_FFFF_FFFE, 64'd2,                  64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{"add_wrap",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'h0,                   1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"sub_ovf",   2'b01, 64'h7FFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0005, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{"sub_small", 2'b01, 64'd10,                  64'd3,                  64'd7,                   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"and",       2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"xor",       2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"sub_negov", 2'b01, 64'h8000_0000_0000_0000, 64'd1,                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"add_minmn", 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0,                   1'b1, 1'b1, 1'b0};
    vecs[8]  = '{"sub_zero",  2'b01, 64'd5,                   64'd5,                  64'h0,                   1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"and_zero",  2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  64'h0,                   1'b0, 1'b1, 1'b0};
    vecs[10] = '{"xor_self",  2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0,                   1'b0, 1'b1, 1'b0};
    vecs[11] = '{"sub_0_min", 2'b01, 64'h0,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{"add_negs",  2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b1};

    // initial reset
    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    tick();
    check_all("rst_init", '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // build non-zero state, then reset while in_valid=1: reset must win
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check_all("pre_rst", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 2'b00, 64'd5, 64'd3);
    rst = 1'b1;
    tick();
    check_all("rst_prio", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // directed table, issued back to back
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      tick();
      check_all(vecs[i].name, vecs[i].ans, vecs[i].ovf, vecs[i].zf, vecs[i].sf, 1'b1);
    end

    // back-to-back then idle hold, with garbage on the idle inputs
    drive(1'b1, 2'b00, 64'd1, 64'd2);
    tick();
    check_all("b2b_add", 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 64'd5, 64'd9);
    tick();
    check_all("b2b_sub", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 2'b10, 64'h0, 64'h0);
    tick();
    check_all("idle1", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    check_all("idle2", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);

    // inputs changing mid-cycle must not reach the outputs
    drive(1'b1, 2'b00, 64'd1, 64'd1);
    tick();
    check_all("mid_base", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.a = 64'd100;
    bus.control = 2'b11;
    #2;
    check_all("mid_chg", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    // random phase with gaps
    m_ans = 64'd2; m_ovf = 1'b0; m_zf = 1'b0; m_sf = 1'b0; m_vld = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic         v;
      logic [1:0]   c;
      logic [W-1:0] ra, rb;
      v  = ($urandom_range(0, 3) != 0);
      c  = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      drive(v, c, ra, rb);
      if (v) model(c, ra, rb);
      m_vld = v;
      tick();
      check_all("rand", m_ans, m_ovf, m_zf, m_sf, m_vld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
